// File: rtl/machine_arb_pkg.sv
// machine_arb_pkg: shared FSM arbiter state encoding and default sizes
package machine_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_LEN_W = 4;
endpackage

// File: rtl/machine_x_arbiter_rr_pick.sv
// rr_pick: combinational winner select over req; round-robin from ptr when MACHINE_ARB_RR_EN, else lowest index
//   req   - request vector
//   ptr   - search start index (ignored in fixed-priority build)
//   valid - some request is set
//   idx   - index of the winner
module rr_pick
    import machine_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);
`ifdef MACHINE_ARB_RR_EN
    int j;
    // Walk downwards so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end
`endif
endmodule

// File: rtl/machine_x_arbiter.sv
// machine_x_arbiter: shares one serial sequence-detector FSM between NREQ requesters in length-bounded bursts
//   CLK, RESET    - clock, async active-low reset
//   req, bit_in   - per-requester request level and serial bit
//   len           - per-requester burst length (0 means 2^LEN_W)
//   m_f           - detect output of the shared FSM
//   m_x, m_clr_n  - serial input and active-low clear to the shared FSM
//   grant         - one-hot grant, zero when idle
//   done, hit, abort, done_id - one-cycle burst result
// Build option MACHINE_ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module machine_x_arbiter
    import machine_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         bit_in,
    input  logic [NREQ*LEN_W-1:0]   len,
    input  logic                    m_f,
    output logic                    m_x,
    output logic                    m_clr_n,
    output logic [NREQ-1:0]         grant,
    output logic                    done,
    output logic                    hit,
    output logic                    abort,
    output logic [$clog2(NREQ)-1:0] done_id
);
    localparam int IW = $clog2(NREQ);
    state_t           state, nxt;
    logic [IW-1:0]    idx, ptr, pick_idx;
    logic             pick_v, acc, aborted;
    logic [LEN_W-1:0] len_sel;
    logic [LEN_W:0]   blen, cnt;
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_v),
        .idx   (pick_idx)
    );
    assign len_sel = len[int'(pick_idx)*LEN_W +: LEN_W];
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = pick_v ? CLEAR : IDLE;
            CLEAR:   nxt = RUN;
            RUN:     nxt = (!req[idx] || cnt == (LEN_W+1)'(1)) ? DONE : RUN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // A zero length field becomes 2^LEN_W through the extra top bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idx     <= '0;
            blen    <= '0;
            cnt     <= '0;
            acc     <= 1'b0;
            aborted <= 1'b0;
        end else if (state == IDLE && pick_v) begin
            idx     <= pick_idx;
            blen    <= {len_sel == '0, len_sel};
            aborted <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= blen;
            acc <= 1'b0;
        end else if (state == RUN) begin
            if (!req[idx]) begin
                aborted <= 1'b1;
            end else begin
                acc <= acc | m_f;
                cnt <= cnt - (LEN_W+1)'(1);
            end
        end
    end
`ifdef MACHINE_ARB_RR_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                     ptr <= '0;
        else if (state == IDLE && pick_v) ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
    end
`else
    assign ptr = '0;
`endif
    assign grant   = (state == CLEAR || state == RUN) ? NREQ'(1) << idx : '0;
    assign m_clr_n = (state != CLEAR);
    assign m_x     = (state == RUN) & bit_in[idx];
    assign done    = (state == DONE);
    // m_f in DONE reflects the last consumed bit, so it joins the accumulator here.
    assign hit     = done & ~aborted & (acc | m_f);
    assign abort   = done & aborted;
    assign done_id = done ? idx : '0;
endmodule
